// File: rtl/brp_gshare.sv
// brp_gshare: gshare/bimodal direction predictor with speculative
// and retired global history and a self-initialising counter table.
module brp_gshare #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 2,
  parameter int GHR_W = 8,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST =
    {1'b0, {(CNT_W-1){1'b1}}};

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] tbl [DEPTH];
  logic [IDX_W-1:0] init_idx;
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] ret_ghr;
  logic [GHR_W-1:0] ret_shift;
  logic [GHR_W-1:0] spec_shift;
  logic [IDX_W-1:0] pc_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] upd_cnt;
  logic [CNT_W-1:0] upd_nx;
  logic             unused_pc;

  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  assign ready = (state == S_RUN);

  // Index formation and zero-latency lookup
  assign pc_idx = pred_pc[IDX_W+1:2];
  assign pred_idx = (MODE == 1) ?
    (pc_idx ^ IDX_W'(spec_ghr)) : pc_idx;
  assign rd_cnt = tbl[pred_idx];
  assign pred_taken = ready & rd_cnt[CNT_W-1];

  // History shifts; a 1-bit history keeps only the new bit
  assign ret_shift  = (ret_ghr << 1) | GHR_W'(upd_taken);
  assign spec_shift = (spec_ghr << 1) | GHR_W'(pred_taken);

  // Saturating next value for the counter being updated
  always_comb begin
    upd_cnt = tbl[upd_idx];
    upd_nx  = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != CNT_MAX) upd_nx = upd_cnt + CNT_W'(1);
    end else begin
      if (upd_cnt != '0) upd_nx = upd_cnt - CNT_W'(1);
    end
  end

  // Next state: leave init once the last entry is written
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT: if (&init_idx) state_nx = S_RUN;
      S_RUN:  state_nx = S_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nx;
  end

  // Init walker: one table entry per cycle
  always_ff @(posedge clk) begin
    if (!rst)                 init_idx <= '0;
    else if (state == S_INIT) init_idx <= init_idx + IDX_W'(1);
  end

  // Counter table: init writes, then resolved-branch updates
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_INIT)
        tbl[init_idx] <= CNT_RST;
      else if (upd_valid)
        tbl[upd_idx] <= upd_nx;
    end
  end

  // Histories; mispredict recovery beats a prediction shift
  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_ghr <= '0;
      ret_ghr  <= '0;
    end else if (state == S_RUN) begin
      if (upd_valid)
        ret_ghr <= ret_shift;
      if (upd_valid && upd_mispredict)
        spec_ghr <= ret_shift;
      else if (pred_valid)
        spec_ghr <= spec_shift;
    end
  end

endmodule

// File: tb/tb_brp_gshare.sv
// tb_brp_gshare: drives a bimodal and a gshare instance with the
// same stimulus and checks both against a behavioural model.
module tb_brp_gshare;

  localparam int IW = 4;
  localparam int CW = 2;
  localparam int GW = 4;
  localparam int D  = 16;
  localparam int H  = 16;
  localparam int CMAX = 3;
  localparam int THR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pv  = 1'b0;
  logic [31:0] pc  = '0;
  logic        uv  = 1'b0;
  logic [3:0]  ui  = '0;
  logic        ut  = 1'b0;
  logic        um  = 1'b0;

  logic        rdy [2];
  logic        tk  [2];
  logic [3:0]  pidx [2];

  int ncmp = 0;
  int nbad = 0;

  int mcnt [D];
  int mspec [2];
  int mret = 0;
  int busy = 0;
  bit mrdy = 1'b0;

  always #5 clk = ~clk;

  brp_gshare #(
    .IDX_W(IW), .CNT_W(CW), .GHR_W(GW), .MODE(0)
  ) u0 (
    .clk(clk), .rst(rst), .ready(rdy[0]),
    .pred_valid(pv), .pred_pc(pc),
    .pred_taken(tk[0]), .pred_idx(pidx[0]),
    .upd_valid(uv), .upd_idx(ui),
    .upd_taken(ut), .upd_mispredict(um)
  );

  brp_gshare #(
    .IDX_W(IW), .CNT_W(CW), .GHR_W(GW), .MODE(1)
  ) u1 (
    .clk(clk), .rst(rst), .ready(rdy[1]),
    .pred_valid(pv), .pred_pc(pc),
    .pred_taken(tk[1]), .pred_idx(pidx[1]),
    .upd_valid(uv), .upd_idx(ui),
    .upd_taken(ut), .upd_mispredict(um)
  );

  function automatic int e_idx(int m);
    int base;
    base = int'((pc / 4) % D);
    return (m == 1) ? (base ^ mspec[1]) : base;
  endfunction

  function automatic bit e_tk(int m);
    return mrdy && (mcnt[e_idx(m)] >= THR);
  endfunction

  // Reference model: advance by one clock using current inputs
  task automatic model_step();
    int ns [2];
    bit et [2];
    if (!rst) begin
      busy = D;
      mrdy = 1'b0;
      mspec[0] = 0;
      mspec[1] = 0;
      mret = 0;
      for (int k = 0; k < D; k++) mcnt[k] = 1;
    end else if (!mrdy) begin
      busy = busy - 1;
      if (busy == 0) mrdy = 1'b1;
    end else begin
      for (int m = 0; m < 2; m++) begin
        et[m] = e_tk(m);
        ns[m] = mspec[m];
        if (uv && um)
          ns[m] = (mret * 2 + int'(ut)) % H;
        else if (pv)
          ns[m] = (mspec[m] * 2 + int'(et[m])) % H;
      end
      if (uv) begin
        mret = (mret * 2 + int'(ut)) % H;
        if (ut) begin
          if (mcnt[ui] < CMAX) mcnt[ui]++;
        end else begin
          if (mcnt[ui] > 0) mcnt[ui]--;
        end
      end
      mspec[0] = ns[0];
      mspec[1] = ns[1];
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic set(input bit r, input bit v,
                     input logic [31:0] p, input bit u,
                     input int i, input bit t, input bit mi);
    rst = r;
    pv  = v;
    pc  = p;
    uv  = u;
    ui  = i[3:0];
    ut  = t;
    um  = mi;
    #1;
  endtask

  task automatic idle(input logic [31:0] p);
    set(1'b1, 1'b0, p, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reinit();
    set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    idle(0);
    repeat (D) tick();
  endtask

  task automatic test_reset();
    set(1'b0, 1'b0, 32'h0000_0024, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (rdy[m] !== 1'b0) begin
          nbad++;
          $display("FAIL reset_ready m=%0d got %b want 0", m, rdy[m]);
        end
        ncmp++;
        if (tk[m] !== 1'b0) begin
          nbad++;
          $display("FAIL reset_taken m=%0d got %b want 0", m, tk[m]);
        end
        ncmp++;
        if (pidx[m] !== 4'd9) begin
          nbad++;
          $display("FAIL reset_idx m=%0d got %0d want 9", m, pidx[m]);
        end
      end
    end
  endtask

  task automatic test_init();
    idle(0);
    for (int i = 0; i <= D; i++) begin
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (rdy[m] !== (i == D)) begin
          nbad++;
          $display("FAIL init_ready m=%0d cyc=%0d got %b want %b",
                   m, i, rdy[m], (i == D));
        end
      end
      if (i < D) tick();
    end
    for (int j = 0; j < D; j++) begin
      idle(32'(j * 4));
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (tk[m] !== 1'b0 || pidx[m] !== 4'(j)) begin
          nbad++;
          $display("FAIL init_sweep m=%0d idx=%0d got %b/%0d want 0/%0d",
                   m, j, tk[m], pidx[m], j);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    bit up [3];
    bit dn [4];
    up = '{1'b0, 1'b1, 1'b1};
    dn = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      set(1'b1, 1'b0, 32'd20, 1'b1, 5, 1'b1, 1'b0);
      ncmp++;
      if (tk[0] !== up[k] || tk[0] !== e_tk(0)) begin
        nbad++;
        $display("FAIL sat_up k=%0d got %b want %b", k, tk[0], up[k]);
      end
      tick();
    end
    idle(32'd20);
    ncmp++;
    if (tk[0] !== 1'b1) begin
      nbad++;
      $display("FAIL sat_top got %b want 1", tk[0]);
    end
    for (int k = 0; k < 4; k++) begin
      set(1'b1, 1'b0, 32'd20, 1'b1, 5, 1'b0, 1'b0);
      ncmp++;
      if (tk[0] !== dn[k] || tk[0] !== e_tk(0)) begin
        nbad++;
        $display("FAIL sat_dn k=%0d got %b want %b", k, tk[0], dn[k]);
      end
      tick();
    end
    set(1'b1, 1'b0, 32'd20, 1'b1, 5, 1'b1, 1'b0);
    tick();
    idle(32'd20);
    ncmp++;
    if (tk[0] !== 1'b0) begin
      nbad++;
      $display("FAIL sat_floor got %b want 0", tk[0]);
    end
    tick();
  endtask

  task automatic test_collision();
    set(1'b1, 1'b0, 32'd36, 1'b1, 9, 1'b1, 1'b0);
    ncmp++;
    if (tk[0] !== 1'b0) begin
      nbad++;
      $display("FAIL coll_same got %b want 0", tk[0]);
    end
    tick();
    idle(32'd36);
    ncmp++;
    if (tk[0] !== 1'b1) begin
      nbad++;
      $display("FAIL coll_next got %b want 1", tk[0]);
    end
    tick();
  endtask

  task automatic test_spec_history();
    int s;
    do_reinit();
    repeat (2) begin
      set(1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
      tick();
    end
    repeat (4) begin
      set(1'b1, 1'b0, 0, 1'b1, 15, 1'b0, 1'b0);
      tick();
    end
    s = 0;
    for (int k = 0; k < 3; k++) begin
      set(1'b1, 1'b1, 32'(s * 4), 1'b0, 0, 1'b0, 1'b0);
      ncmp++;
      if (pidx[1] !== 4'd0 || tk[1] !== 1'b1) begin
        nbad++;
        $display("FAIL spec_pred k=%0d got %0d/%b want 0/1",
                 k, pidx[1], tk[1]);
      end
      tick();
      s = s * 2 + 1;
    end
    idle(0);
    ncmp++;
    if (pidx[1] !== 4'd7) begin
      nbad++;
      $display("FAIL spec_ghr got %0d want 7", pidx[1]);
    end
    set(1'b1, 1'b0, 0, 1'b1, 15, 1'b0, 1'b1);
    tick();
    idle(0);
    ncmp++;
    if (pidx[1] !== 4'd0) begin
      nbad++;
      $display("FAIL spec_recover got %0d want 0", pidx[1]);
    end
  endtask

  task automatic test_priority();
    set(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    set(1'b1, 1'b1, 32'd4, 1'b1, 15, 1'b1, 1'b1);
    ncmp++;
    if (pidx[1] !== 4'd0 || tk[1] !== 1'b1) begin
      nbad++;
      $display("FAIL prio_pre got %0d/%b want 0/1", pidx[1], tk[1]);
    end
    tick();
    idle(0);
    ncmp++;
    if (pidx[1] !== 4'd1) begin
      nbad++;
      $display("FAIL prio_ghr got %0d want 1", pidx[1]);
    end
    tick();
  endtask

  task automatic test_mid_init_reset();
    set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    set(1'b1, 1'b1, 0, 1'b1, 3, 1'b1, 1'b1);
    repeat (7) tick();
    ncmp++;
    if (rdy[0] !== 1'b0 || rdy[1] !== 1'b0) begin
      nbad++;
      $display("FAIL midinit_pre got %b%b want 00", rdy[0], rdy[1]);
    end
    set(1'b0, 1'b1, 0, 1'b1, 3, 1'b1, 1'b1);
    tick();
    set(1'b1, 1'b1, 0, 1'b1, 3, 1'b1, 1'b1);
    for (int i = 0; i <= D; i++) begin
      if (i == D) idle(0);
      ncmp++;
      if (rdy[1] !== (i == D) || rdy[0] !== (i == D)) begin
        nbad++;
        $display("FAIL midinit_ready cyc=%0d got %b%b want %b",
                 i, rdy[0], rdy[1], (i == D));
      end
      if (i < D) tick();
    end
    ncmp++;
    if (pidx[1] !== 4'd0) begin
      nbad++;
      $display("FAIL midinit_ghr got %0d want 0", pidx[1]);
    end
    idle(32'd12);
    ncmp++;
    if (tk[0] !== 1'b0) begin
      nbad++;
      $display("FAIL midinit_cnt got %b want 0", tk[0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      set(($urandom % 400) != 0, 1'($urandom),
          $urandom, ($urandom % 3) != 0,
          int'($urandom % D), 1'($urandom), ($urandom % 4) == 0);
      for (int m = 0; m < 2; m++) begin
        ncmp++;
        if (rdy[m] !== mrdy || tk[m] !== e_tk(m) ||
            pidx[m] !== 4'(e_idx(m))) begin
          nbad++;
          $display("FAIL rand n=%0d m=%0d got %b/%b/%0d want %b/%b/%0d",
                   n, m, rdy[m], tk[m], pidx[m],
                   mrdy, e_tk(m), e_idx(m));
        end
      end
      tick();
    end
  endtask

  initial begin
    mspec[0] = 0;
    mspec[1] = 0;
    for (int k = 0; k < D; k++) mcnt[k] = 1;
    @(negedge clk);
    test_reset();
    test_init();
    test_saturation();
    test_collision();
    test_spec_history();
    test_priority();
    test_mid_init_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
